reaction_game_ctrl: RTL and testbench

//  Game sequencer for the FPGA reaction timer; sits between the debounced buttons and the display.

---
 rtl/reaction_game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction timer game sequencer.
// Flow: arm a pseudo-random delay, light GO, time the reaction in ms,
// and keep the best time seen since reset.
// Every output is registered and is computed from the next-state values,
// so each output changes on the clock edge after its cause.
module reaction_game_ctrl #(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          MAX_TIME     = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_ms,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic [13:0] number,
  output logic        go_led,
  output logic        blink,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FOUL   = 3'd4
  } state_t;

  localparam logic [13:0] MAX_T = 14'(MAX_TIME);
  localparam logic [13:0] MIN_D = 14'(MIN_DELAY_MS);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [13:0] delay, delay_nxt;
  logic [13:0] timer, timer_nxt;
  logic [13:0] result, result_nxt;
  logic [13:0] best, best_nxt;
  logic        new_best, new_best_nxt;

  logic [13:0] number_nxt;
  logic        go_led_nxt;
  logic        blink_nxt;
  logic        busy_nxt;

  // Wait length: the fixed minimum plus the low LFSR bits as random extra.
  function automatic logic [13:0] delay_load(input logic [15:0] l);
    return MIN_D + 14'(l[RAND_BITS-1:0]);
  endfunction

  // Countdown that holds at zero instead of wrapping.
  function automatic logic [13:0] delay_dec(input logic [13:0] d);
    return (d == 14'd0) ? 14'd0 : d - 14'd1;
  endfunction

  // Reaction timer increment that saturates at MAX_TIME.
  function automatic logic [13:0] timer_inc(input logic [13:0] t);
    return (t >= MAX_T) ? MAX_T : t + 14'd1;
  endfunction

  // Free-running Fibonacci LFSR (taps 16,14,13,11); sampled at each round start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // State register together with the game datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      delay    <= 14'd0;
      timer    <= 14'd0;
      result   <= 14'd0;
      best     <= MAX_T;
      new_best <= 1'b0;
    end else begin
      state    <= state_nxt;
      delay    <= delay_nxt;
      timer    <= timer_nxt;
      result   <= result_nxt;
      best     <= best_nxt;
      new_best <= new_best_nxt;
    end
  end

  // Next-state and datapath update; within each state the first matching event wins.
  always_comb begin
    state_nxt    = state;
    delay_nxt    = delay;
    timer_nxt    = timer;
    result_nxt   = result;
    best_nxt     = best;
    new_best_nxt = new_best;
    case (state)
      S_IDLE, S_RESULT, S_FOUL: begin
        // btn_react is ignored here, so start always takes priority.
        if (btn_start) begin
          state_nxt = S_WAIT;
          delay_nxt = delay_load(lfsr);
        end
      end
      S_WAIT: begin
        // A press before GO is a foul, even on the tick that would end the wait.
        if (btn_react) begin
          state_nxt = S_FOUL;
        end else if (tick_ms) begin
          delay_nxt = delay_dec(delay);
          if (delay <= 14'd1) begin
            state_nxt = S_GO;
            timer_nxt = 14'd0;
          end
        end
      end
      S_GO: begin
        // The press captures the timer value before any same-cycle tick.
        if (btn_react) begin
          state_nxt  = S_RESULT;
          result_nxt = timer;
          if (timer < best) begin
            best_nxt     = timer;
            new_best_nxt = 1'b1;
          end else begin
            new_best_nxt = 1'b0;
          end
        end else if (tick_ms) begin
          if (timer >= MAX_T - 14'd1) begin
            // Timed out: show the ceiling, never counts as a best time.
            state_nxt    = S_RESULT;
            timer_nxt    = MAX_T;
            result_nxt   = MAX_T;
            new_best_nxt = 1'b0;
          end else begin
            timer_nxt = timer_inc(timer);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with it.
  always_comb begin
    number_nxt = number;
    go_led_nxt = 1'b0;
    blink_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    case (state_nxt)
      S_IDLE: begin
        number_nxt = best_nxt;
      end
      S_WAIT: begin
        // The display keeps its last value while waiting for GO.
        busy_nxt = 1'b1;
      end
      S_GO: begin
        go_led_nxt = 1'b1;
        busy_nxt   = 1'b1;
        number_nxt = timer_nxt;
      end
      S_RESULT: begin
        number_nxt = result_nxt;
        blink_nxt  = new_best_nxt;
      end
      S_FOUL: begin
        number_nxt = 14'd0;
        blink_nxt  = 1'b1;
      end
      default: begin
        number_nxt = best_nxt;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number <= MAX_T;
      go_led <= 1'b0;
      blink  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      number <= number_nxt;
      go_led <= go_led_nxt;
      blink  <= blink_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl with a short random delay (5 ms + 0..3 ms).
module tb_reaction_game_ctrl;

  localparam int MIN_D = 5;
  localparam int RB    = 2;
  localparam int MAXT  = 9999;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int P_IDLE   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_GO     = 2;
  localparam int P_RESULT = 3;
  localparam int P_FOUL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic [13:0] number;
  logic        go_led;
  logic        blink;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model of the game, expressed as round phases and counters
  int          m_ph;
  int          m_wait;
  int          m_elapsed;
  int          m_best;
  int          m_last;
  int          m_newbest;
  int          m_number;
  logic [15:0] m_lfsr;

  reaction_game_ctrl #(
    .MIN_DELAY_MS(MIN_D),
    .RAND_BITS   (RB),
    .MAX_TIME    (MAXT),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_ms  (tick_ms),
    .btn_start(btn_start),
    .btn_react(btn_react),
    .number   (number),
    .go_led   (go_led),
    .blink    (blink),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph      = P_IDLE;
    m_wait    = 0;
    m_elapsed = 0;
    m_best    = MAXT;
    m_last    = 0;
    m_newbest = 0;
    m_number  = MAXT;
    m_lfsr    = SEED;
  endtask

  task automatic model_update(input bit t, input bit s, input bit r);
    case (m_ph)
      P_IDLE, P_RESULT, P_FOUL: begin
        if (s) begin
          m_ph   = P_WAIT;
          m_wait = MIN_D + (int'(m_lfsr) % (1 << RB));
        end
      end
      P_WAIT: begin
        if (r) m_ph = P_FOUL;
        else if (t) begin
          m_wait = m_wait - 1;
          if (m_wait <= 0) begin
            m_ph      = P_GO;
            m_elapsed = 0;
          end
        end
      end
      P_GO: begin
        if (r) begin
          m_last    = m_elapsed;
          m_newbest = (m_elapsed < m_best) ? 1 : 0;
          if (m_newbest == 1) m_best = m_elapsed;
          m_ph = P_RESULT;
        end else if (t) begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == MAXT) begin
            m_last    = MAXT;
            m_newbest = 0;
            m_ph      = P_RESULT;
          end
        end
      end
      default: m_ph = P_IDLE;
    endcase
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    case (m_ph)
      P_IDLE:   m_number = m_best;
      P_GO:     m_number = m_elapsed;
      P_RESULT: m_number = m_last;
      P_FOUL:   m_number = 0;
      default:  ;
    endcase
  endtask

  task automatic compare();
    chk("number", int'(number), m_number);
    chk("go_led", int'(go_led), (m_ph == P_GO) ? 1 : 0);
    chk("busy",   int'(busy),   (m_ph == P_WAIT || m_ph == P_GO) ? 1 : 0);
    chk("blink",  int'(blink),
        (m_ph == P_FOUL) ? 1 : ((m_ph == P_RESULT) ? m_newbest : 0));
  endtask

  // one clock: drive inputs, advance model after the edge, check on the falling edge
  task automatic step(input bit t, input bit s, input bit r);
    tick_ms   = t;
    btn_start = s;
    btn_react = r;
    @(posedge clk);
    #1;
    model_update(t, s, r);
    tick_ms   = 1'b0;
    btn_start = 1'b0;
    btn_react = 1'b0;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    tick_ms   = 1'b0;
    btn_start = 1'b0;
    btn_react = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      compare();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    compare();
  endtask

  task automatic run_to_go(output int ticks);
    ticks = 0;
    while (m_ph == P_WAIT && ticks < 20) begin
      step(1'b1, 1'b0, 1'b0);
      ticks++;
    end
    chk("reached_go", int'(go_led), 1);
  endtask

  task automatic tick_to(input int target);
    int guard = 0;
    while (m_ph == P_GO && m_elapsed < target && guard < 12000) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("tick_target", int'(number), target);
  endtask

  initial begin
    int ticks;

    // 1: reset state
    do_reset(10);
    chk("rst_number", int'(number), 9999);
    chk("rst_go", int'(go_led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_blink", int'(blink), 0);

    // react in IDLE is ignored
    step(1'b0, 1'b0, 1'b1);
    chk("idle_react_ignored", int'(busy), 0);

    // 2: first round, react at 37, new best
    step(1'b0, 1'b1, 1'b0);
    chk("t2_busy", int'(busy), 1);
    run_to_go(ticks);
    chk("t2_go_ticks_5_to_8", (ticks >= 5 && ticks <= 8) ? 1 : 0, 1);
    chk("t2_go_number0", int'(number), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_count1", int'(number), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("go_start_ignored", int'(go_led), 1);
    tick_to(37);
    step(1'b0, 1'b0, 1'b1);
    chk("t2_result", int'(number), 37);
    chk("t2_blink", int'(blink), 1);

    // 3: second round react at 52, not a best
    step(1'b0, 1'b1, 1'b1);
    chk("start_wins_over_react", int'(busy), 1);
    run_to_go(ticks);
    tick_to(52);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_result", int'(number), 52);
    chk("t3_blink", int'(blink), 0);

    // equal to best does not blink
    step(1'b0, 1'b1, 1'b0);
    run_to_go(ticks);
    tick_to(37);
    step(1'b0, 1'b0, 1'b1);
    chk("equal_result", int'(number), 37);
    chk("equal_blink", int'(blink), 0);

    // reset mid-round clears best
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_reset(2);
    chk("t3_rst_number", int'(number), 9999);
    chk("t3_rst_busy", int'(busy), 0);

    // 4: foul during WAIT
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_foul_number", int'(number), 0);
    chk("t4_foul_blink", int'(blink), 1);
    chk("t4_foul_go", int'(go_led), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("t4_restart_busy", int'(busy), 1);

    // 6a: tick and react same cycle at 20
    run_to_go(ticks);
    tick_to(20);
    step(1'b1, 1'b0, 1'b1);
    chk("t6_same_cycle_result", int'(number), 20);
    chk("t6_blink", int'(blink), 1);

    // 6b: react on the last WAIT tick
    step(1'b0, 1'b1, 1'b0);
    while (m_ph == P_WAIT && m_wait > 1) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("t6_last_tick_foul", int'(number), 0);
    chk("t6_last_tick_go", int'(go_led), 0);

    // 5: timeout after 9999 ticks in GO
    step(1'b0, 1'b1, 1'b0);
    run_to_go(ticks);
    tick_to(9998);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_timeout_number", int'(number), 9999);
    chk("t5_timeout_blink", int'(blink), 0);
    chk("t5_timeout_go", int'(go_led), 0);

    // best still 20 after the timeout: a 21 is not a new best
    step(1'b0, 1'b1, 1'b0);
    run_to_go(ticks);
    tick_to(21);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_best_kept_number", int'(number), 21);
    chk("t5_best_kept_blink", int'(blink), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
